// File: rtl/eth_sw_pkg.sv
// rtl/eth_sw_pkg.sv - shared types and defaults for the two-port packet switch
package eth_sw_pkg;

    typedef logic [31:0] eth_word_t;

    typedef struct packed {
        logic      eop;
        eth_word_t data;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, SEND, GAP} egress_state_e;
    typedef enum logic {PORT_A, PORT_B} port_sel_e;

    localparam eth_word_t ADDR_A_DEF        = 32'hA0A0_A0A0;
    localparam eth_word_t ADDR_B_DEF        = 32'hB0B0_B0B0;
    localparam int        FIFO_DEPTH_DEF    = 32;
    localparam int        MAX_PKT_WORDS_DEF = 16;

    function automatic port_sel_e other_port(input port_sel_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/eth_pkt_fifo.sv
// rtl/eth_pkt_fifo.sv - ingress framing, admission, truncation and packet storage
module eth_pkt_fifo
    import eth_sw_pkg::*;
#(
    parameter eth_word_t ADDR_A        = ADDR_A_DEF,
    parameter eth_word_t ADDR_B        = ADDR_B_DEF,
    parameter int        FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int        MAX_PKT_WORDS = MAX_PKT_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        pop,
    output logic [32:0] head_entry,
    output logic [31:0] head_dest,
    output logic        pkt_avail,
    output logic        drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   MAX_C   = (AW + 1)'(MAX_PKT_WORDS);
    localparam logic [WW-1:0] MAX_W   = WW'(MAX_PKT_WORDS);

    eth_word_t     mem_data [FIFO_DEPTH];
    logic          mem_eop  [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, pkt_cnt, used, free;
    logic [WW-1:0] wcnt;
    logic          prev_valid, storing;
    logic          sop, admit, wr_en, wr_eop, commit, pop_eop;

    assign used = wr_ptr - rd_ptr;
    assign free = DEPTH_C - used;

    always_comb begin
        sop     = in_valid & ~prev_valid;
        admit   = sop & ((in_data == ADDR_A) | (in_data == ADDR_B)) & (free >= MAX_C);
        wr_en   = admit | (in_valid & prev_valid & storing & (wcnt < MAX_W));
        wr_eop  = admit ? (MAX_PKT_WORDS == 1) : (wcnt == MAX_W - 1'b1);
        commit  = ~in_valid & prev_valid & storing;
        pop_eop = pop & mem_eop[rd_ptr[AW-1:0]];
        drop    = sop & ~admit;
    end

    // The true last word is only known once valid drops, so its eop bit is patched at commit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= in_data;
            mem_eop[wr_ptr[AW-1:0]]  <= wr_eop;
        end else if (commit) begin
            mem_eop[wr_ptr[AW-1:0] - 1'b1] <= 1'b1;
        end
    end

    // prev_valid resets high so a packet already in progress at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            wcnt       <= '0;
            prev_valid <= 1'b1;
            storing    <= 1'b0;
        end else begin
            prev_valid <= in_valid;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (admit) begin
                storing <= 1'b1;
                wcnt    <= WW'(1);
            end else if (wr_en) begin
                wcnt <= wcnt + 1'b1;
            end
            if (commit) storing <= 1'b0;
            case ({commit, pop_eop})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    assign head_entry = {mem_eop[rd_ptr[AW-1:0]], mem_data[rd_ptr[AW-1:0]]};
    assign head_dest  = mem_data[rd_ptr[AW-1:0]];
    assign pkt_avail  = (pkt_cnt != '0);

endmodule

// File: rtl/eth_switch_2p.sv
// rtl/eth_switch_2p.sv - two-port store-and-forward switch with round-robin egress
module eth_switch_2p
    import eth_sw_pkg::*;
#(
    parameter eth_word_t ADDR_A        = ADDR_A_DEF,
    parameter eth_word_t ADDR_B        = ADDR_B_DEF,
    parameter int        FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int        MAX_PKT_WORDS = MAX_PKT_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Ain,
    input  logic [31:0] inDataA,
    input  logic        Bin,
    input  logic [31:0] inDataB,
    output logic        Aout,
    output logic [31:0] outDataA,
    output logic        Bout,
    output logic [31:0] outDataB,
    output logic [15:0] drop_cnt_a,
    output logic [15:0] drop_cnt_b
);

    logic [1:0]    pop, pkt_avail, drop, head_eop, busy, gnt_v, contend, load;
    eth_word_t     head_data [2];
    eth_word_t     head_dest [2];
    eth_word_t     port_addr [2];
    logic [1:0]    cand      [2];
    egress_state_e state_q   [2];
    egress_state_e state_d   [2];
    port_sel_e     sel_q     [2];
    port_sel_e     rr_q      [2];
    port_sel_e     gnt       [2];
    port_sel_e     src       [2];
    logic          out_v     [2];
    eth_word_t     out_d     [2];
    logic [15:0]   dcnt      [2];

    assign port_addr[0] = ADDR_A;
    assign port_addr[1] = ADDR_B;

    for (genvar f = 0; f < 2; f++) begin : g_ing
        fifo_entry_t entry;
        eth_pkt_fifo #(
            .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
            .FIFO_DEPTH(FIFO_DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)
        ) u_fifo (
            .clk(clk), .rst_n(rst_n),
            .in_valid((f == 0) ? Ain : Bin),
            .in_data((f == 0) ? inDataA : inDataB),
            .pop(pop[f]), .head_entry(entry), .head_dest(head_dest[f]),
            .pkt_avail(pkt_avail[f]), .drop(drop[f])
        );
        assign head_eop[f]  = entry.eop;
        assign head_data[f] = entry.data;
    end

    // A FIFO mid-burst is hidden from the other egress: its head is a payload word, not a destination.
    always_comb begin
        busy = '0;
        for (int p = 0; p < 2; p++) begin
            if (state_q[p] == SEND) busy[sel_q[p]] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 2; f++) begin
                cand[p][f] = pkt_avail[f] & ~busy[f] & (head_dest[f] == port_addr[p]);
            end
            contend[p] = &cand[p];
            gnt_v[p]   = |cand[p];
            gnt[p]     = contend[p] ? rr_q[p] : (cand[p][0] ? PORT_A : PORT_B);
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                IDLE:    if (gnt_v[p]) state_d[p] = head_eop[gnt[p]] ? GAP : SEND;
                SEND:    if (head_eop[sel_q[p]]) state_d[p] = GAP;
                GAP:     state_d[p] = IDLE;
                default: state_d[p] = IDLE;
            endcase
        end
    end

    always_comb begin
        pop = '0;
        for (int p = 0; p < 2; p++) begin
            src[p]  = (state_q[p] == IDLE) ? gnt[p] : sel_q[p];
            load[p] = ((state_q[p] == IDLE) & gnt_v[p]) | (state_q[p] == SEND);
            if (load[p]) pop[src[p]] = 1'b1;
        end
    end

    // Round-robin pointer only moves on a contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                sel_q[p]   <= PORT_A;
                rr_q[p]    <= PORT_A;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                if ((state_q[p] == IDLE) && gnt_v[p]) sel_q[p] <= gnt[p];
                if ((state_q[p] == IDLE) && contend[p]) rr_q[p] <= other_port(gnt[p]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                out_v[p] <= 1'b0;
                out_d[p] <= '0;
                dcnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                out_v[p] <= load[p];
                out_d[p] <= load[p] ? head_data[src[p]] : '0;
                if (drop[p] && (dcnt[p] != 16'hFFFF)) dcnt[p] <= dcnt[p] + 1'b1;
            end
        end
    end

    assign Aout       = out_v[0];
    assign outDataA   = out_d[0];
    assign Bout       = out_v[1];
    assign outDataB   = out_d[1];
    assign drop_cnt_a = dcnt[0];
    assign drop_cnt_b = dcnt[1];

endmodule

// File: tb/tb_eth_switch_2p.sv
// tb/tb_eth_switch_2p.sv - randomized and directed check of eth_switch_2p against a packet-level model
module tb_eth_switch_2p;

    localparam logic [31:0] AA = 32'hA0A0_A0A0;
    localparam logic [31:0] AB = 32'hB0B0_B0B0;
    localparam int          DEPTH = 32;
    localparam int          MAXW  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Ain = 1'b0, Bin = 1'b0;
    logic [31:0] inDataA = '0, inDataB = '0;
    logic        Aout, Bout;
    logic [31:0] outDataA, outDataB;
    logic [15:0] drop_cnt_a, drop_cnt_b;

    eth_switch_2p dut (
        .clk(clk), .rst_n(rst_n),
        .Ain(Ain), .inDataA(inDataA), .Bin(Bin), .inDataB(inDataB),
        .Aout(Aout), .outDataA(outDataA), .Bout(Bout), .outDataB(outDataB),
        .drop_cnt_a(drop_cnt_a), .drop_cnt_b(drop_cnt_b)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;

    // Expected {valid, data} per output port, indexed by clock edge number.
    logic [32:0] sched [2][0:32767];

    int          prev [2], storing [2], cur_len [2], occ [2], popping [2];
    int          port_free [2], fifo_free [2], rr [2], m_drop [2];
    logic [31:0] fw [2][0:63];
    int          fw_wr [2], fw_rd [2];
    int          pl [2][0:63], pc [2][0:63];
    int          pk_wr [2], pk_rd [2];

    logic [31:0] cap_a[$], cap_b[$];
    int          cap_ea[$], cap_eb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int n);
        for (int f = 0; f < 2; f++) begin
            prev[f] = 1; storing[f] = 0; cur_len[f] = 0; occ[f] = 0; popping[f] = 0;
            port_free[f] = 0; fifo_free[f] = 0; rr[f] = 0; m_drop[f] = 0;
            fw_wr[f] = 0; fw_rd[f] = 0; pk_wr[f] = 0; pk_rd[f] = 0;
        end
        for (int k = 0; k < 64; k++) begin
            sched[0][(n + k) % 32768] = '0;
            sched[1][(n + k) % 32768] = '0;
        end
    endtask

    task automatic model_push(input int f, input logic [31:0] d);
        fw[f][fw_wr[f] % 64] = d;
        fw_wr[f]++;
        occ[f]++;
    endtask

    task automatic model_step(input int n);
        logic        v;
        logic [31:0] d;
        logic [1:0]  cand;
        int          g, len;
        for (int f = 0; f < 2; f++) begin
            v = (f == 0) ? Ain : Bin;
            d = (f == 0) ? inDataA : inDataB;
            if (v && prev[f] == 0) begin
                if ((d == AA || d == AB) && (DEPTH - occ[f]) >= MAXW) begin
                    storing[f] = 1; cur_len[f] = 1; model_push(f, d);
                end else if (m_drop[f] < 65535) begin
                    m_drop[f]++;
                end
            end else if (v && prev[f] != 0 && storing[f] != 0) begin
                if (cur_len[f] < MAXW) begin
                    cur_len[f]++; model_push(f, d);
                end
            end else if (!v && prev[f] != 0 && storing[f] != 0) begin
                pl[f][pk_wr[f] % 64] = cur_len[f];
                pc[f][pk_wr[f] % 64] = n;
                pk_wr[f]++;
                storing[f] = 0;
            end
            prev[f] = v ? 1 : 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (n >= port_free[p]) begin
                cand = '0;
                for (int f = 0; f < 2; f++) begin
                    if (pk_rd[f] != pk_wr[f] && pc[f][pk_rd[f] % 64] < n && n >= fifo_free[f] &&
                        fw[f][fw_rd[f] % 64] == ((p == 0) ? AA : AB))
                        cand[f] = 1'b1;
                end
                if (cand != 2'b00) begin
                    g = (cand == 2'b11) ? rr[p] : (cand[0] ? 0 : 1);
                    if (cand == 2'b11) rr[p] = 1 - g;
                    len = pl[g][pk_rd[g] % 64];
                    for (int k = 0; k < len; k++)
                        sched[p][(n + k) % 32768] = {1'b1, fw[g][(fw_rd[g] + k) % 64]};
                    fw_rd[g] += len;
                    pk_rd[g]++;
                    port_free[p] = n + len + 1;
                    fifo_free[g] = n + len;
                    popping[g]   = len;
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            if (popping[f] > 0) begin
                occ[f]--; popping[f]--;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) model_reset(cyc);
        else model_step(cyc);
    end

    always @(negedge clk) begin
        check("out_a", {31'd0, Aout, outDataA}, rst_n ? {31'd0, sched[0][cyc % 32768]} : 64'd0);
        check("out_b", {31'd0, Bout, outDataB}, rst_n ? {31'd0, sched[1][cyc % 32768]} : 64'd0);
        check("drop_a", {48'd0, drop_cnt_a}, rst_n ? {48'd0, 16'(m_drop[0])} : 64'd0);
        check("drop_b", {48'd0, drop_cnt_b}, rst_n ? {48'd0, 16'(m_drop[1])} : 64'd0);
        if (rst_n && Aout) begin cap_a.push_back(outDataA); cap_ea.push_back(cyc); end
        if (rst_n && Bout) begin cap_b.push_back(outDataB); cap_eb.push_back(cyc); end
    end

    task automatic drive(input int port, input logic v, input logic [31:0] d);
        if (port == 0) begin Ain = v; inDataA = d; end
        else begin Bin = v; inDataB = d; end
    endtask

    task automatic send(input int port, input logic [31:0] w[$], input int gap);
        foreach (w[i]) begin
            @(negedge clk);
            drive(port, 1'b1, w[i]);
        end
        @(negedge clk);
        drive(port, 1'b0, 32'd0);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic clear_caps();
        cap_a.delete(); cap_b.delete(); cap_ea.delete(); cap_eb.delete();
    endtask

    task automatic check_cap(input string nm, input int port, input logic [31:0] e[$]);
        int          sz;
        logic [31:0] act;
        sz = (port == 0) ? cap_a.size() : cap_b.size();
        check($sformatf("%s_len", nm), 64'(sz), 64'(e.size()));
        foreach (e[i]) begin
            act = (i < sz) ? ((port == 0) ? cap_a[i] : cap_b[i]) : 32'hDEAD_BEEF;
            check($sformatf("%s_w%0d", nm, i), {32'd0, act}, {32'd0, e[i]});
        end
    endtask

    task automatic rand_port(input int port, input int npkt);
        logic [31:0] q[$];
        int          r, len;
        for (int k = 0; k < npkt; k++) begin
            q.delete();
            r = $urandom_range(0, 9);
            q.push_back((r < 5) ? AA : (r < 9) ? AB : (32'h5555_0000 | 32'(r)));
            len = $urandom_range(1, 20);
            for (int i = 1; i < len; i++)
                q.push_back(($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? AA : AB) : $urandom);
            send(port, q, $urandom_range(1, 3));
        end
    endtask

    initial begin
        logic [31:0] qa[$], qb[$], exp_q[$];
        int          t0;
        for (int i = 0; i < 32768; i++) begin
            sched[0][i] = '0;
            sched[1][i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, Aout, Bout, outDataA, outDataB[31:0]}, 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: single A->B packet, latency C+1
        clear_caps();
        qa = {AB, 32'd1, 32'd2, 32'd3};
        send(0, qa, 1);
        t0 = cyc;
        repeat (12) @(negedge clk);
        check_cap("t1_b", 1, qa);
        check("t1_a_len", 64'(cap_a.size()), 64'd0);
        check("t1_latency", 64'((cap_eb.size() > 0) ? cap_eb[0] : -1), 64'(t0 + 2));
        check("t1_drops", {32'd0, drop_cnt_a, drop_cnt_b}, 64'd0);

        // 2: crossing traffic in parallel
        clear_caps();
        qa = {AB, 32'd21, 32'd22};
        qb = {AA, 32'd31, 32'd32};
        fork
            send(0, qa, 1);
            send(1, qb, 1);
        join
        repeat (12) @(negedge clk);
        check_cap("t2_a", 0, qb);
        check_cap("t2_b", 1, qa);
        check("t2_same_cycle", 64'((cap_ea.size() > 0) ? cap_ea[0] : -1),
              64'((cap_eb.size() > 0) ? cap_eb[0] : -2));

        // 3: contention on port A, then pointer moves to B
        clear_caps();
        qa = {AA, 32'h11};
        qb = {AA, 32'h22};
        fork
            send(0, qa, 1);
            send(1, qb, 1);
        join
        repeat (12) @(negedge clk);
        exp_q = {AA, 32'h11, AA, 32'h22};
        check_cap("t3_first", 0, exp_q);
        check("t3_gap", 64'((cap_ea.size() > 2) ? cap_ea[2] - cap_ea[1] : 0), 64'd2);
        clear_caps();
        qa = {AA, 32'h33};
        qb = {AA, 32'h44};
        fork
            send(0, qa, 1);
            send(1, qb, 1);
        join
        repeat (12) @(negedge clk);
        exp_q = {AA, 32'h44, AA, 32'h33};
        check_cap("t3_second", 0, exp_q);

        // 4: unknown destination dropped
        clear_caps();
        qa = {32'h1234_5678, 32'd9, 32'd9};
        send(0, qa, 1);
        repeat (10) @(negedge clk);
        check("t4_no_out", 64'(cap_a.size() + cap_b.size()), 64'd0);
        check("t4_drop_a", {48'd0, drop_cnt_a}, 64'd1);

        // 5: truncation to 16 words
        clear_caps();
        qb.delete();
        qb.push_back(AA);
        for (int i = 1; i < 20; i++) qb.push_back(32'(i));
        send(1, qb, 1);
        repeat (25) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < MAXW; i++) exp_q.push_back(qb[i]);
        check_cap("t5_a", 0, exp_q);
        check("t5_drop_b", {48'd0, drop_cnt_b}, 64'd0);

        // randomized traffic on both ingresses
        fork
            rand_port(0, 120);
            rand_port(1, 120);
        join
        repeat (150) @(negedge clk);

        // 6: reset mid-output, released while Bin is high
        clear_caps();
        qa = {AB, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        send(0, qa, 1);
        for (int i = 0; i < 10 && !Bout; i++) @(negedge clk);
        check("t6_bout_seen", {63'd0, Bout}, 64'd1);
        #2 rst_n = 1'b0;
        Bin = 1'b1;
        inDataB = AA;
        clear_caps();
        #1 check("t6_abort", {30'd0, Aout, Bout, outDataA, outDataB}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            inDataB = $urandom;
        end
        @(negedge clk);
        Bin = 1'b0;
        inDataB = '0;
        repeat (30) @(negedge clk);
        check("t6_nothing", 64'(cap_a.size() + cap_b.size()), 64'd0);
        check("t6_drops", {32'd0, drop_cnt_a, drop_cnt_b}, 64'd0);
        qa = {AB, 32'h55, 32'h66};
        send(0, qa, 1);
        repeat (12) @(negedge clk);
        check_cap("t6_clean", 1, qa);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
